// File: rtl/blink_pattern_detector.sv
// Purpose: recognise the blink pattern ON6/OFF4/ON6/OFF4/ON7 (in sample ticks) on an async input.
// Latency: detected rises on the 3rd clk edge after blink_in falls at the end of seg4 (TICK_DIV=1).
// Backpressure: none; blink_in is sampled continuously and the outputs are fire-and-forget pulses.
//
// Ports:
//   clk          system clock, all state on its rising edge
//   reset        asynchronous active-low reset
//   blink_in     asynchronous blink level, 1 = ON
//   detected     one-cycle pulse when a full valid pattern ends
//   error        one-cycle pulse when a pattern violation is found
//   busy         high whenever the FSM is not in IDLE
//   seg_idx      segment being measured (0..4), 0 outside MEASURE
//   match_count  saturating count of detected patterns
//
// Build option: define BLINK_TOLERANCE_EN to accept runs within +/-1 tick of the
// expected length (overflow then fires at expected+2); otherwise runs must be exact.

module blink_pattern_detector #(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       blink_in,
  output logic       detected,
  output logic       error,
  output logic       busy,
  output logic [2:0] seg_idx,
  output logic [7:0] match_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_ERROR,
    ST_WAIT_LOW
  } state_t;

  localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);
  localparam logic [7:0] GAP_MAX   = 8'(GAP_TICKS - 1);

  state_t     state, state_nxt;
  logic       sync_meta, sync_s;
  logic [7:0] presc;
  logic       tick;
  logic [3:0] run_cnt, run_cnt_nxt;
  logic [2:0] seg_idx_nxt;
  logic [7:0] gap_cnt, gap_cnt_nxt;
  logic       detected_nxt, error_nxt;

  logic [3:0] exp_len_cur, run_lo, run_hi;
  logic       in_range;
  logic       seg_level;

  // Expected run length of each segment, in ticks.
  function automatic logic [3:0] exp_len(input logic [2:0] idx);
    case (idx)
      3'd0:    exp_len = 4'd6;
      3'd1:    exp_len = 4'd4;
      3'd2:    exp_len = 4'd6;
      3'd3:    exp_len = 4'd4;
      default: exp_len = 4'd7;
    endcase
  endfunction

  // Two-flop synchronizer; only sync_s is ever looked at by the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= blink_in;
      sync_s    <= sync_meta;
    end
  end

  // Free-running prescaler; with TICK_DIV=1 the counter sits at 0 and tick is constant high.
  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= 8'd0;
    end else if (tick) begin
      presc <= 8'd0;
    end else begin
      presc <= presc + 8'd1;
    end
  end

  // Even segments are ON, odd segments are OFF.
  assign seg_level = ~seg_idx[0];

  always_comb begin
    exp_len_cur = exp_len(seg_idx);
`ifdef BLINK_TOLERANCE_EN
    run_lo = exp_len_cur - 4'd1;
    run_hi = exp_len_cur + 4'd1;
`else
    run_lo = exp_len_cur;
    run_hi = exp_len_cur;
`endif
    in_range = (run_cnt >= run_lo) && (run_cnt <= run_hi);
  end

  // State register, including the registered pulse outputs and match counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      run_cnt     <= 4'd0;
      seg_idx     <= 3'd0;
      gap_cnt     <= 8'd0;
      detected    <= 1'b0;
      error       <= 1'b0;
      match_count <= 8'd0;
    end else begin
      state    <= state_nxt;
      run_cnt  <= run_cnt_nxt;
      seg_idx  <= seg_idx_nxt;
      gap_cnt  <= gap_cnt_nxt;
      detected <= detected_nxt;
      error    <= error_nxt;
      if (detected_nxt && (match_count != 8'hFF)) begin
        match_count <= match_count + 8'd1;
      end
    end
  end

  // Next-state and run/segment/gap counters.
  always_comb begin
    state_nxt   = state;
    run_cnt_nxt = run_cnt;
    seg_idx_nxt = seg_idx;
    gap_cnt_nxt = gap_cnt;
    case (state)
      ST_IDLE: begin
        if (tick && sync_s) begin
          state_nxt   = ST_MEASURE;
          seg_idx_nxt = 3'd0;
          run_cnt_nxt = 4'd1;
        end
      end
      ST_MEASURE: begin
        if (tick) begin
          if (sync_s == seg_level) begin
            // Stopping at run_hi means run_cnt never goes beyond run_hi, so 4 bits never wrap.
            if (run_cnt == run_hi) begin
              state_nxt   = ST_ERROR;
              run_cnt_nxt = 4'd0;
              seg_idx_nxt = 3'd0;
            end else begin
              run_cnt_nxt = run_cnt + 4'd1;
            end
          end else if (!in_range) begin
            state_nxt   = ST_ERROR;
            run_cnt_nxt = 4'd0;
            seg_idx_nxt = 3'd0;
          end else if (seg_idx == 3'd4) begin
            state_nxt   = ST_IDLE;
            run_cnt_nxt = 4'd0;
            seg_idx_nxt = 3'd0;
          end else begin
            seg_idx_nxt = seg_idx + 3'd1;
            run_cnt_nxt = 4'd1;
          end
        end
      end
      ST_ERROR: begin
        // Leaves unconditionally, independent of tick, so error stays one cycle wide.
        state_nxt   = ST_WAIT_LOW;
        gap_cnt_nxt = 8'd0;
      end
      ST_WAIT_LOW: begin
        if (tick) begin
          if (sync_s) begin
            gap_cnt_nxt = 8'd0;
          end else if (gap_cnt == GAP_MAX) begin
            state_nxt   = ST_IDLE;
            gap_cnt_nxt = 8'd0;
          end else begin
            gap_cnt_nxt = gap_cnt + 8'd1;
          end
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        run_cnt_nxt = 4'd0;
        seg_idx_nxt = 3'd0;
        gap_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Outputs: MEASURE->IDLE only happens on a good seg4 end; ERROR is only entered from MEASURE.
  always_comb begin
    detected_nxt = (state == ST_MEASURE) && (state_nxt == ST_IDLE);
    error_nxt    = (state_nxt == ST_ERROR);
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_blink_pattern_detector.sv
// Purpose: directed self-checking bench for blink_pattern_detector (TICK_DIV=1, GAP_TICKS=4).
// Latency: checks the 3-edge fall-to-detected latency and the error/WAIT_LOW timing.
// Backpressure: n/a; stimulus is driven one level per clock edge.

module tb_blink_pattern_detector;

  logic       clk;
  logic       reset;
  logic       blink_in;
  logic       detected;
  logic       error;
  logic       busy;
  logic [2:0] seg_idx;
  logic [7:0] match_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int det_cnt  = 0;
  int err_cnt  = 0;
  int det_cyc  = 0;
  int err_cyc  = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  logic det_prev = 1'b0;
  logic err_prev = 1'b0;

  blink_pattern_detector #(
    .TICK_DIV  (1),
    .GAP_TICKS (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .blink_in    (blink_in),
    .detected    (detected),
    .error       (error),
    .busy        (busy),
    .seg_idx     (seg_idx),
    .match_count (match_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (detected) begin
      det_cnt = det_cnt + 1;
      det_cyc = cyc;
    end
    if (error) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (detected && error) both_cnt = both_cnt + 1;
    if ((detected && det_prev) || (error && err_prev)) wide_cnt = wide_cnt + 1;
    det_prev = detected;
    err_prev = error;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hold blink_in at v for n rising edges; returns 1 time unit after the last edge.
  task automatic drive(input logic v, input int n);
    blink_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_pattern(input int a, input int b, input int c, input int d, input int e);
    drive(1'b1, a);
    drive(1'b0, b);
    drive(1'b1, c);
    drive(1'b0, d);
    drive(1'b1, e);
  endtask

  int start_cyc;
  int fall_cyc;
  int d0;
  int e0;

  initial begin
    reset    = 1'b0;
    blink_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with blink_in high and the clock running.
    check_eq("rst_detected", detected, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_seg_idx", seg_idx, 0);
    check_eq("rst_match_count", match_count, 0);
    blink_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 4);

    // Nominal pattern with mid-pattern segment checks.
    drive(1'b1, 6);
    drive(1'b0, 4);
    check_eq("mid_seg1_idx", seg_idx, 1);
    check_eq("mid_busy", busy, 1);
    drive(1'b1, 6);
    check_eq("mid_seg2_idx", seg_idx, 2);
    drive(1'b0, 4);
    drive(1'b1, 7);
    fall_cyc = cyc;
    drive(1'b0, 6);
    check_eq("nominal_det_count", det_cnt, 1);
    check_eq("nominal_det_latency", det_cyc - fall_cyc, 3);
    check_eq("nominal_match_count", match_count, 1);
    check_eq("nominal_no_error", err_cnt, 0);
    check_eq("nominal_idle_busy", busy, 0);
    check_eq("nominal_idle_seg", seg_idx, 0);

`ifdef BLINK_TOLERANCE_EN
    // Loose pattern is accepted, then seg4 of 9 overflows.
    d0 = det_cnt;
    e0 = err_cnt;
    run_pattern(5, 5, 7, 3, 8);
    drive(1'b0, 6);
    check_eq("tol_loose_det", det_cnt - d0, 1);
    check_eq("tol_loose_no_err", err_cnt - e0, 0);
    run_pattern(6, 4, 6, 4, 9);
    drive(1'b0, 8);
    check_eq("tol_seg4_9_err", err_cnt - e0, 1);
    check_eq("tol_seg4_9_no_det", det_cnt - d0, 1);
    check_eq("tol_recovered_busy", busy, 0);
`else
    // seg0 ON for 7: error on the 7th sampled ON tick, then 4 low ticks in WAIT_LOW.
    e0 = err_cnt;
    start_cyc = cyc;
    drive(1'b1, 7);
    drive(1'b0, 3);
    check_eq("long_seg0_err", err_cnt - e0, 1);
    check_eq("long_seg0_err_cycle", err_cyc - start_cyc, 9);
    check_eq("wait_low_busy", busy, 1);
    check_eq("wait_low_seg", seg_idx, 0);
    drive(1'b0, 3);
    check_eq("wait_low_still_busy", busy, 1);
    drive(1'b0, 1);
    check_eq("wait_low_done_idle", busy, 0);
    // seg0 of 5 is out of range without tolerance.
    e0 = err_cnt;
    d0 = det_cnt;
    drive(1'b1, 5);
    drive(1'b0, 8);
    check_eq("short_seg0_err", err_cnt - e0, 1);
    check_eq("short_seg0_no_det", det_cnt - d0, 0);
`endif

    // seg1 OFF for 3 then ON: error, seg_idx back to 0, no detection.
    e0 = err_cnt;
    d0 = det_cnt;
    drive(1'b1, 6);
    drive(1'b0, 3);
    drive(1'b1, 3);
    drive(1'b0, 2);
    check_eq("short_seg1_wait_busy", busy, 1);
    check_eq("short_seg1_seg_idx", seg_idx, 0);
    drive(1'b0, 8);
    check_eq("short_seg1_err", err_cnt - e0, 1);
    check_eq("short_seg1_no_det", det_cnt - d0, 0);
    check_eq("short_seg1_idle", busy, 0);

    // Reset during seg2: outputs clear at once, no error pulse, next pattern detected.
    e0 = err_cnt;
    drive(1'b1, 6);
    drive(1'b0, 4);
    drive(1'b1, 3);
    reset = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_seg_idx", seg_idx, 0);
    check_eq("midrst_match_count", match_count, 0);
    check_eq("midrst_detected", detected, 0);
    check_eq("midrst_error", error, 0);
    blink_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b0, 6);
    check_eq("midrst_no_error", err_cnt - e0, 0);
    d0 = det_cnt;
    run_pattern(6, 4, 6, 4, 7);
    drive(1'b0, 6);
    check_eq("postrst_det", det_cnt - d0, 1);
    check_eq("postrst_match_count", match_count, 1);

    // 256 back-to-back patterns: count climbs to 255 and holds.
    d0 = det_cnt;
    for (int i = 0; i < 253; i++) begin
      run_pattern(6, 4, 6, 4, 7);
      drive(1'b0, 1);
    end
    drive(1'b0, 4);
    check_eq("sat_at_254", match_count, 254);
    for (int i = 0; i < 3; i++) begin
      run_pattern(6, 4, 6, 4, 7);
      drive(1'b0, 1);
    end
    drive(1'b0, 4);
    check_eq("sat_hold_255", match_count, 255);
    check_eq("sat_det_pulses", det_cnt - d0, 256);

    check_eq("never_both_high", both_cnt, 0);
    check_eq("pulses_one_cycle", wide_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blink_pattern_detector.md
BLINK_PATTERN_DETECTOR -- requirements
Module: blink_pattern_detector

Interface
REQ-001 Parameter: TICK_DIV, default 1, clock cycles per sample tick (range 1..255).
REQ-002 Parameter: GAP_TICKS, default 4, low ticks required after an error before re-arming.
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 blink_in  input  1  asynchronous blink signal from the blinking machine; 1 = ON.
REQ-006 detected  output  1  one-cycle pulse when a complete valid pattern ends.
REQ-007 error  output  1  one-cycle pulse when a pattern violation is found.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 seg_idx  output  3  index of the segment currently being measured, 0..4.
REQ-010 match_count  output  8  count of detected patterns; saturates at 255.

Function
REQ-011 blink_in shall pass through a 2-flop synchronizer; the second flop (s) is the only sampled value.
REQ-012 A free-running prescaler shall assert tick once every TICK_DIV cycles; with TICK_DIV=1, tick is high every cycle.
REQ-013 The expected pattern shall be: seg0 ON 6, seg1 OFF 4, seg2 ON 6, seg3 OFF 4, seg4 ON 7, measured in ticks.
REQ-014 The FSM states shall be IDLE, MEASURE, ERROR and WAIT_LOW; all state changes occur only on tick, except ERROR, which leaves after exactly one cycle.
REQ-015 IDLE: on tick with s=1, the FSM shall move to MEASURE with seg_idx=0 and run count=1; with s=0, it stays in IDLE.
REQ-016 MEASURE, same level as the segment: on tick, run count shall increment; reaching expected length+1 shall go to ERROR on that tick.
REQ-017 MEASURE, level change: an in-range run count for seg 0..3 shall increment seg_idx and set run count=1; an out-of-range count shall go to ERROR.
REQ-018 MEASURE, seg4 ending (s=0): an in-range count shall pulse detected, increment match_count (saturating) and return to IDLE.
REQ-019 ERROR: error shall be high for exactly one cycle, then the FSM goes to WAIT_LOW.
REQ-020 WAIT_LOW: the FSM shall return to IDLE after GAP_TICKS consecutive ticks with s=0; any s=1 restarts that count.
REQ-021 detected and error shall be registered, one cycle wide, and never both high in the same cycle.
REQ-022 detected shall rise on the 3rd rising edge after blink_in falls at the end of seg4 (TICK_DIV=1).
REQ-023 The run counter shall be 4 bits wide and shall never wrap, because overflow is caught first by REQ-016.
REQ-024 seg_idx shall read 0 in IDLE, ERROR and WAIT_LOW.

Reset
REQ-025 While reset=0, the following shall hold regardless of clk: state=IDLE; synchronizer flops, prescaler, run counter, seg_idx, match_count, detected, error and busy all 0.
REQ-026 Reset asserted mid-pattern shall abandon the pattern silently, with no error pulse.
REQ-027 After reset release, the first detection shall need a full pattern starting from IDLE.

Configuration
REQ-028 Macro BLINK_TOLERANCE_EN, when defined, shall make a run in range if its length is within expected ±1 ticks; overflow then triggers at expected+2.
REQ-029 Without BLINK_TOLERANCE_EN, a run shall be in range only if it exactly equals the expected length.

Verification
REQ-030 TICK_DIV=1: drive 6 on, 4 off, 6 on, 4 off, 7 on, then low -> detected high for one cycle 3 edges after the final fall; match_count=1; error never high.
REQ-031 Drive seg0 ON for 7 cycles (no tolerance) -> error pulse on the 7th sampled ON tick; WAIT_LOW entered; IDLE re-entered after 4 low cycles.
REQ-032 Drive seg1 OFF for 3 cycles then ON -> error pulse; seg_idx returns to 0; detected stays 0.
REQ-033 BLINK_TOLERANCE_EN defined: drive 5,5,7,3,8 -> detected pulse; then drive 6,4,6,4,9 -> error pulse.
REQ-034 Assert reset during seg2 -> all outputs 0 immediately; no error pulse; a following full pattern -> detected.
REQ-035 Run 256 valid patterns back-to-back -> match_count holds at 255.
